// File: rtl/tff_seq_ctrl_if.sv
// Command/status bundle between a sequencer client and tff_seq_ctrl.
// master drives the command side, slave (the controller) drives the
// toggle vector, the bank state and the busy/done handshake.
interface tff_seq_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, dir, load_val, term_val, hold, abort,
    input  t, q, busy, done
  );

  modport slave (
    input  start, dir, load_val, term_val, hold, abort,
    output t, q, busy, done
  );

endinterface

// File: rtl/tff_seq_ctrl.sv
// Sequencing controller for a bank of toggle flip-flop cells.
// A start command loads a value and then counts up or down, one step per
// non-held clock, until the captured terminal value is reached. Every
// change of the bank goes through the toggle vector t, so an external tff
// bank driven by the same t tracks q exactly.
module tff_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clk,
  input logic      clrn,
  tff_seq_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] t_comb;
  logic [WIDTH-1:0] step_t;
  logic             step_acc;
  logic             match;

  assign match = (q_q == term_q);

  // Toggle pattern for one count step: bit i flips when all lower bits are
  // 1 (up) or all lower bits are 0 (down); bit 0 always flips.
  always_comb begin
    step_t   = '0;
    step_acc = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      step_t[i] = step_acc;
      step_acc  = step_acc & (dir_q ? q_q[i] : ~q_q[i]);
    end
  end

  // Next-state, capture and toggle-vector decode; abort > match > hold > step.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    load_d  = load_q;
    term_d  = term_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    t_comb  = '0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          dir_d   = bus.dir;
          load_d  = bus.load_val;
          term_d  = bus.term_val;
          busy_d  = 1'b1;
        end
      end
      StLoad: begin
        if (bus.abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          // Flip exactly the bits that differ so q lands on the load value.
          t_comb  = q_q ^ load_q;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (match) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!bus.hold) begin
          t_comb = step_t;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign q_d = q_q ^ t_comb;

  // Control state and handshake registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Command parameters captured on an accepted start.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dir_q  <= 1'b0;
      load_q <= '0;
      term_q <= '0;
    end else begin
      dir_q  <= dir_d;
      load_q <= load_d;
      term_q <= term_d;
    end
  end

  // Internal toggle bank: each cell is q <= q ^ t.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.t    = t_comb;
  assign bus.q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Testbench for tff_seq_ctrl: directed vector table, reset sequence and a
// randomized run checked against a value-level reference model.
module tb_tff_seq_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic clrn;

  always #5 clk = ~clk;

  tff_seq_if #(.WIDTH(W)) bus ();

  tff_seq_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Directed vectors: inputs for one cycle, t expected during that cycle,
  // q/busy/done expected after its closing edge.
  typedef struct {
    logic       start, dir, hold, abort;
    logic [7:0] load, term;
    logic [7:0] et, eq;
    logic       eb, ed;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic d, input logic h, input logic a,
                     input logic [7:0] lv, input logic [7:0] tv,
                     input logic [7:0] et, input logic [7:0] eq,
                     input logic eb, input logic ed);
    vec_t v;
    v.start = s; v.dir = d; v.hold = h; v.abort = a;
    v.load = lv; v.term = tv; v.et = et; v.eq = eq; v.eb = eb; v.ed = ed;
    vq.push_back(v);
  endtask

  // Reference model: tracks the counter as a number; t is whatever flips
  // the current value into the next one.
  int         m_mode, n_mode;  // 0 idle, 1 load, 2 run
  logic       m_dir, n_dir;
  logic [7:0] m_load, n_load, m_term, n_term, m_q, m_nq;
  logic       m_busy, n_busy, m_done, n_done;

  task automatic model_eval();
    n_mode = m_mode; n_dir = m_dir; n_load = m_load; n_term = m_term;
    n_busy = m_busy; n_done = 1'b0; m_nq = m_q;
    if (m_mode == 0) begin
      if (bus.start) begin
        n_mode = 1; n_dir = bus.dir; n_load = bus.load_val; n_term = bus.term_val;
        n_busy = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (bus.abort) begin
        n_mode = 0; n_busy = 1'b0;
      end else begin
        m_nq = m_load; n_mode = 2;
      end
    end else begin
      if (bus.abort) begin
        n_mode = 0; n_busy = 1'b0;
      end else if (m_q == m_term) begin
        n_mode = 0; n_busy = 1'b0; n_done = 1'b1;
      end else if (!bus.hold) begin
        m_nq = m_dir ? m_q + 8'd1 : m_q - 8'd1;
      end
    end
  endtask

  task automatic model_commit();
    m_mode = n_mode; m_dir = n_dir; m_load = n_load; m_term = n_term;
    m_busy = n_busy; m_done = n_done; m_q = m_nq;
  endtask

  task automatic rand_cycle();
    logic [7:0] lv, off;
    logic       d;
    lv  = 8'($urandom_range(0, 255));
    off = 8'($urandom_range(0, 12));
    d   = 1'($urandom_range(0, 1));
    bus.start    = ($urandom_range(0, 3) == 0);
    bus.dir      = d;
    bus.load_val = lv;
    if ($urandom_range(0, 7) == 0) bus.term_val = 8'($urandom_range(0, 255));
    else bus.term_val = d ? lv + off : lv - off;
    bus.hold  = ($urandom_range(0, 3) == 0);
    bus.abort = ($urandom_range(0, 63) == 0);
    #2;
    model_eval();
    check("rand_t", {24'd0, bus.t}, {24'd0, m_q ^ m_nq});
    @(posedge clk);
    model_commit();
    #1;
    check("rand_q", {24'd0, bus.q}, {24'd0, m_q});
    check("rand_busy", {31'd0, bus.busy}, {31'd0, m_busy});
    check("rand_done", {31'd0, bus.done}, {31'd0, m_done});
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.dir = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
    bus.load_val = 8'h00; bus.term_val = 8'h00;
  endtask

  initial begin
    // Up 03 -> 07
    add(1, 1, 0, 0, 8'h03, 8'h07, 8'h00, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 8'h03, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h07, 8'h04, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h05, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 8'h06, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h07, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h07, 0, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h07, 0, 0);
    // Down 01 -> FE through the wrap
    add(1, 0, 0, 0, 8'h01, 8'hFE, 8'h00, 8'h07, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h06, 8'h01, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'hFE, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hFE, 0, 1);
    // load == term, started while done is high
    add(1, 1, 0, 0, 8'h55, 8'h55, 8'h00, 8'hFE, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'hAB, 8'h55, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h55, 0, 1);
    // Up 10 -> 14, three held cycles, re-pulse while busy, hold at match
    add(1, 1, 0, 0, 8'h10, 8'h14, 8'h00, 8'h55, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h45, 8'h10, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 1, 0);
    add(1, 0, 0, 0, 8'hAA, 8'hAA, 8'h01, 8'h11, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 8'h12, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h13, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h07, 8'h14, 1, 0);
    add(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h14, 0, 1);
    // Abort in RUN at q=12, then abort in LOAD
    add(1, 1, 0, 0, 8'h10, 8'h20, 8'h00, 8'h14, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 8'h10, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h11, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 8'h12, 1, 0);
    add(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h12, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 0, 0);
    add(1, 0, 0, 0, 8'h80, 8'h7F, 8'h00, 8'h12, 1, 0);
    add(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h12, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 0, 0);

    // Power-on reset
    clrn = 1'b0;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_t", {24'd0, bus.t}, 32'd0);
    check("rst_q", {24'd0, bus.q}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    clrn = 1'b1;

    // Directed table
    foreach (vq[i]) begin
      bus.start = vq[i].start; bus.dir = vq[i].dir;
      bus.hold = vq[i].hold; bus.abort = vq[i].abort;
      bus.load_val = vq[i].load; bus.term_val = vq[i].term;
      #2;
      check($sformatf("v%0d_t", i), {24'd0, bus.t}, {24'd0, vq[i].et});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_q", i), {24'd0, bus.q}, {24'd0, vq[i].eq});
      check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, {31'd0, vq[i].eb});
      check($sformatf("v%0d_done", i), {31'd0, bus.done}, {31'd0, vq[i].ed});
    end

    // Asynchronous reset in the middle of a run
    idle_inputs();
    bus.start = 1'b1; bus.dir = 1'b1; bus.load_val = 8'h00; bus.term_val = 8'hF0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    check("mid_q", {24'd0, bus.q}, 32'h04);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_q", {24'd0, bus.q}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_t", {24'd0, bus.t}, 32'd0);
    bus.start = 1'b1; bus.load_val = 8'h33; bus.term_val = 8'h44;
    @(posedge clk);
    #1;
    check("rst_start_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_start_q", {24'd0, bus.q}, 32'd0);
    check("rst_start_t", {24'd0, bus.t}, 32'd0);
    idle_inputs();
    #2;
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // Randomized run against the model, starting from the reset state
    m_mode = 0; m_dir = 1'b0; m_load = 8'h00; m_term = 8'h00; m_q = 8'h00;
    m_busy = 1'b0; m_done = 1'b0;
    for (int k = 0; k < 3000; k++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tff_seq_ctrl.md
# tff_seq_ctrl

Sequencing controller for a bank of WIDTH toggle flip-flop cells (q <= t&~q | ~t&q per bit). On a start command it loads a start value and counts up or down to a programmed terminal value, one step per enabled clock. All state changes go through the toggle vector t, so the same t bus can drive an external tff bank. The block sits beside the counter/timer datapath in the lab designs and reports completion with a busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, number of toggle cells (counter width), >= 2

Ports:
- clk  input  1  clock; all state changes on its rising edge
- clrn  input  1  reset, asynchronous and active-low
- start  input  1  command pulse; accepted only in IDLE
- dir  input  1  count direction: 1 = up, 0 = down; captured at start
- load_val  input  WIDTH  start value; captured at start
- term_val  input  WIDTH  terminal value; captured at start
- hold  input  1  pause: when 1 in RUN, t = 0 and no state change
- abort  input  1  cancel: LOAD/RUN -> IDLE, no done pulse
- t  output  WIDTH  toggle vector to the tff bank, combinational from state and q
- q  output  WIDTH  internal toggle bank state, registered, q <= q ^ t
- busy  output  1  registered, 1 in LOAD and RUN
- done  output  1  registered one-cycle completion pulse

## Operation
- Reset (clrn=0, asynchronous): state IDLE, q = 0, busy = 0, done = 0, captured dir/load/term = 0; t = 0 while in IDLE.
- States: IDLE, LOAD, RUN.
- IDLE: t = 0. start=1 at edge -> capture dir, load_val, term_val; state LOAD; busy <= 1.
- LOAD: t = q ^ load_cap (one cycle; q becomes load_cap at next edge); next state RUN. abort=1 overrides: t = 0, next IDLE.
- RUN, priority abort > match > hold > step:
  - abort=1: t = 0; next IDLE; busy <= 0; done stays 0; q holds.
  - q == term_cap: t = 0; next IDLE; busy <= 0; done <= 1.
  - hold=1: t = 0; stay RUN.
  - else step: t[0] = 1; t[i] = &q[i-1:0] (up) or &~q[i-1:0] (down), i >= 1.
- Arithmetic is modulo 2^WIDTH: up from all-ones wraps to 0, down from 0 wraps to all-ones; no overflow flag.
- Step count N = (term - load) mod 2^WIDTH (up) or (load - term) mod 2^WIDTH (down); load == term gives N = 0.
- done is 1 for exactly one cycle and cleared on the next edge regardless of inputs.
- start while busy is ignored; input changes after capture have no effect until the next start.
- start in the cycle done is high is accepted (state already IDLE).

## Timing
- Start sampled at edge E0 -> busy = 1 after E0, LOAD during cycle E0..E1, q = load_val after E1.
- Each non-hold RUN cycle advances q by one at the closing edge; q = term after edge E1+N (+ hold cycles).
- Match cycle follows; done = 1 and busy = 0 after edge E1+N+1+H (H = hold cycles in RUN); total latency start-edge to done = N+2+H cycles.
- hold asserted in the match cycle does not delay completion (match has priority).
- t is combinational; external tff bank sees it within the same cycle and updates on the same edge as q.
- Reset mid-operation: immediate return to reset values, no done pulse.

## Test plan
- Reset with clrn=0 mid-RUN (WIDTH=8) -> q=0, busy=0, done=0, t=0 immediately; start ignored while clrn=0.
- start, dir=1, load=8'h03, term=8'h07 -> q sequence 03,04,05,06,07; done pulse 6 cycles after start edge; busy low same edge.
- start, dir=0, load=8'h01, term=8'hFE -> q 01,00,FF,FE (wrap); done after 5 cycles; t=8'hFF on the 00->FF step.
- start, load=term=8'h55 -> q=55 after LOAD, done 2 cycles after start, zero steps.
- Up 8'h10->8'h14 with hold=1 for 3 RUN cycles, then start re-pulsed while busy -> q frozen 3 cycles, done at 9 cycles, re-pulse ignored.
- abort=1 in RUN at q=8'h12 -> IDLE next edge, q stays 12, done never asserts; start same cycle as a later done pulse is accepted.
